// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed two-display 7-segment scan and reassembles it into hh:mm:ss.
// Frames are accepted only once all six digits are captured and the time is in range.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num0_scan_select,
  input  logic [1:0] num1_scan_select,
  input  logic [6:0] num0_seg7,
  input  logic [6:0] num1_seg7,
  output logic [1:0] hour_h,
  output logic [3:0] hour_l,
  output logic [2:0] min_h,
  output logic [3:0] min_l,
  output logic [2:0] sec_h,
  output logic [3:0] sec_l,
  output logic       time_valid,
  output logic       time_update,
  output logic       seg_err,
  output logic       range_err,
  output logic [7:0] err_count
);

  // {valid, digit}; invalid patterns return 0 in the low nibble
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
      default:    decode = 5'h00;
    endcase
  endfunction

  logic [3:0]      sel0_q, cnt0_q, cnt0_d;
  logic [1:0]      sel1_q;
  logic [3:0]      cnt1_q, cnt1_d;
  logic            elig0, elig1, samp0, samp1;
  logic [4:0]      dec0, dec1;
  logic            cap0, cap1, bad0, bad1;
  logic [5:0]      cap_bits, mask_q, mask_next;
  logic            done, check_q, frame_ok, changed;
  logic [5:0][3:0] hold_q, hold_d, frame_q;
  logic [7:0]      hour_val;
  logic [8:0]      err_sum;

  always_comb begin
    cnt0_d = (num0_scan_select != sel0_q) ? 4'd1 :
             (cnt0_q == 4'hF) ? cnt0_q : cnt0_q + 4'd1;
    cnt1_d = (num1_scan_select != sel1_q) ? 4'd1 :
             (cnt1_q == 4'hF) ? cnt1_q : cnt1_q + 4'd1;
  end

  assign elig0 = (num0_scan_select == 4'b0111) || (num0_scan_select == 4'b1011) ||
                 (num0_scan_select == 4'b1101) || (num0_scan_select == 4'b1110);
  assign elig1 = (num1_scan_select == 2'b01) || (num1_scan_select == 2'b10);

  // Sample on the STABLE_CYC-th identical cycle only; the counter keeps climbing afterwards
  assign samp0 = elig0 && (num0_scan_select == sel0_q) && (cnt0_q == 4'(STABLE_CYC - 1));
  assign samp1 = elig1 && (num1_scan_select == sel1_q) && (cnt1_q == 4'(STABLE_CYC - 1));

  assign dec0 = decode(num0_seg7);
  assign dec1 = decode(num1_seg7);
  assign cap0 = samp0 && dec0[4];
  assign cap1 = samp1 && dec1[4];
  assign bad0 = samp0 && !dec0[4] && (num0_seg7 != 7'd0);
  assign bad1 = samp1 && !dec1[4] && (num1_seg7 != 7'd0);

  // Inverted one-hot-low selects map straight onto mask bits: [5:2] hours/minutes, [1:0] seconds
  assign cap_bits  = {cap0 ? ~num0_scan_select : 4'b0000, cap1 ? ~num1_scan_select : 2'b00};
  assign mask_next = mask_q | cap_bits;
  assign done      = (mask_next == 6'h3F);

  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < 6; i++) begin
      if (cap_bits[i]) hold_d[i] = (i >= 2) ? dec0[3:0] : dec1[3:0];
    end
  end

  assign hour_val = {4'd0, frame_q[5]} * 8'd10 + {4'd0, frame_q[4]};
  assign frame_ok = (frame_q[5] <= 4'd2) && (frame_q[4] <= 4'd9) && (hour_val <= 8'd23) &&
                    (frame_q[3] <= 4'd5) && (frame_q[2] <= 4'd9) &&
                    (frame_q[1] <= 4'd5) && (frame_q[0] <= 4'd9);
  assign changed  = {hour_h, hour_l, min_h, min_l, sec_h, sec_l} !=
                    {frame_q[5][1:0], frame_q[4], frame_q[3][2:0], frame_q[2],
                     frame_q[1][2:0], frame_q[0]};
  assign range_err = check_q && !frame_ok;
  assign err_sum   = {1'b0, err_count} + {7'd0, seg_err} + {7'd0, range_err};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel0_q      <= 4'hF;
      sel1_q      <= 2'b11;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      mask_q      <= '0;
      hold_q      <= '0;
      frame_q     <= '0;
      check_q     <= 1'b0;
      hour_h      <= '0;
      hour_l      <= '0;
      min_h       <= '0;
      min_l       <= '0;
      sec_h       <= '0;
      sec_l       <= '0;
      time_valid  <= 1'b0;
      time_update <= 1'b0;
      seg_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      sel0_q      <= num0_scan_select;
      sel1_q      <= num1_scan_select;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      hold_q      <= hold_d;
      mask_q      <= done ? 6'h00 : mask_next;
      check_q     <= done;
      seg_err     <= bad0 || bad1;
      time_update <= check_q && frame_ok && (changed || !time_valid);
      err_count   <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (done) frame_q <= hold_d;
      if (check_q && frame_ok) begin
        hour_h     <= frame_q[5][1:0];
        hour_l     <= frame_q[4];
        min_h      <= frame_q[3][2:0];
        min_l      <= frame_q[2];
        sec_h      <= frame_q[1][2:0];
        sec_l      <= frame_q[0];
        time_valid <= 1'b1;
      end
    end
  end

endmodule
